// File: rtl/reaction_sequencer.sv
// Reaction-time game sequencer: random countdown, go light, timing and best score.
// Define REACTION_FALSE_START_EN to turn early presses into a FOUL state.
module reaction_sequencer #(
  parameter int MIN_DELAY = 500,
  parameter int MAX_COUNT = 9999
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Key,
  input  logic        SW,
  input  logic        Tick,
  output logic [2:0]  State,
  output logic        Go,
  output logic [13:0] Time_ms,
  output logic [13:0] Best_ms,
  output logic        New_best
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_FINISH = 3'd2;
  localparam logic [2:0] S_SCORE  = 3'd3;
`ifdef REACTION_FALSE_START_EN
  localparam logic [2:0] S_FOUL   = 3'd4;
`endif

  localparam logic [13:0] MAX_T     = 14'(MAX_COUNT);
  localparam logic [15:0] MIN_D     = 16'(MIN_DELAY);
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  logic [2:0]  state_q, state_d;
  logic        go_q, go_d;
  logic [13:0] tm_q, tm_d;
  logic [13:0] best_q, best_d;
  logic        nb_q, nb_d;
  logic [15:0] cnt_q, cnt_d;
  logic        key_q, key_d;
  logic [15:0] lfsr_q, lfsr_d;

  logic        press;
  logic        foul;
  logic        lfsr_fb;
  logic [15:0] cnt_dec;
  logic [13:0] tm_inc;

  // Taps 16,14,13,11 in right-shift form; a nonzero seed keeps it nonzero.
  always_comb begin
    lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    lfsr_d  = {lfsr_fb, lfsr_q[15:1]};
  end

  always_comb begin
    key_d   = Key;
    press   = Key & ~key_q;
    cnt_dec = (Tick && cnt_q != 16'd0) ? cnt_q - 16'd1 : cnt_q;
    tm_inc  = (tm_q < MAX_T) ? tm_q + 14'd1 : MAX_T;
  end

`ifdef REACTION_FALSE_START_EN
  assign foul = press;
`else
  assign foul = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    go_d    = go_q;
    tm_d    = tm_q;
    best_d  = best_q;
    nb_d    = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        go_d = 1'b0;
        if (press) begin
          if (SW) begin
            state_d = S_SCORE;
          end else begin
            state_d = S_START;
            cnt_d   = MIN_D + {5'd0, lfsr_q[10:0]};
            tm_d    = '0;
          end
        end
      end
      S_START: begin
        if (go_q) begin
          // A press wins over a coincident Tick: the frozen time excludes it.
          if (press) begin
            state_d = S_FINISH;
            go_d    = 1'b0;
            if (tm_q < best_q) begin
              best_d = tm_q;
              nb_d   = 1'b1;
            end
          end else if (Tick) begin
            tm_d = tm_inc;
            if (tm_inc == MAX_T) begin
              state_d = S_FINISH;
              go_d    = 1'b0;
            end
          end
        end else if (foul) begin
`ifdef REACTION_FALSE_START_EN
          state_d = S_FOUL;
`endif
          tm_d = MAX_T;
        end else begin
          cnt_d = cnt_dec;
          go_d  = (cnt_dec == 16'd0);
        end
      end
      S_FINISH: begin
        go_d = 1'b0;
        if (press) state_d = S_IDLE;
      end
      S_SCORE: begin
        go_d = 1'b0;
        if (press && !SW) state_d = S_IDLE;
      end
`ifdef REACTION_FALSE_START_EN
      S_FOUL: begin
        go_d = 1'b0;
        if (press) state_d = S_IDLE;
      end
`endif
      default: begin
        state_d = S_IDLE;
        go_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      go_q    <= 1'b0;
      tm_q    <= '0;
      best_q  <= MAX_T;
      nb_q    <= 1'b0;
      cnt_q   <= '0;
      key_q   <= 1'b0;
      lfsr_q  <= LFSR_SEED;
    end else begin
      state_q <= state_d;
      go_q    <= go_d;
      tm_q    <= tm_d;
      best_q  <= best_d;
      nb_q    <= nb_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      lfsr_q  <= lfsr_d;
    end
  end

  assign State    = state_q;
  assign Go       = go_q;
  assign Time_ms  = (state_q == S_SCORE) ? best_q : tm_q;
  assign Best_ms  = best_q;
  assign New_best = nb_q;

endmodule

// File: tb/tb_reaction_sequencer.sv
// Bench for reaction_sequencer: vector table, game scenarios, random run vs model.
// Honours REACTION_FALSE_START_EN for the early-press expectations.
module tb_reaction_sequencer;

  localparam int MIN  = 500;
  localparam int MAXC = 9999;
  localparam int SPAN = 2047;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Key = 1'b0;
  logic        SW = 1'b0;
  logic        Tick = 1'b0;
  logic [2:0]  State;
  logic        Go;
  logic [13:0] Time_ms;
  logic [13:0] Best_ms;
  logic        New_best;

  int total = 0;
  int bad = 0;

  reaction_sequencer dut (
    .Clock(Clock), .Reset(Reset), .Key(Key), .SW(SW), .Tick(Tick),
    .State(State), .Go(Go), .Time_ms(Time_ms), .Best_ms(Best_ms),
    .New_best(New_best)
  );

  always #5 Clock = ~Clock;

`ifdef REACTION_FALSE_START_EN
  localparam bit FSE = 1'b1;
`else
  localparam bit FSE = 1'b0;
`endif

  // Game-level reference: state as plain ints, countdown length unknown
  // to the model and accepted only inside its legal window.
  int m_state, m_time, m_best, m_cnt;
  bit m_go, m_nb, m_pk;
  bit mdl_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    total++;
    if (act !== 32'(exp)) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic mdl_edge(input bit r, input bit k, input bit s, input bit t);
    bit press;
    if (r) begin
      m_state = 0; m_go = 0; m_time = 0; m_best = MAXC;
      m_nb = 0; m_pk = 0; m_cnt = 0;
      return;
    end
    press = k && !m_pk;
    m_pk = k;
    m_nb = 0;
    case (m_state)
      0: if (press) begin
        if (s) m_state = 3;
        else begin
          m_state = 1; m_go = 0; m_time = 0; m_cnt = 0;
        end
      end
      1: if (m_go) begin
        if (press) begin
          m_state = 2; m_go = 0;
          if (m_time < m_best) begin m_best = m_time; m_nb = 1; end
        end else if (t) begin
          m_time = (m_time + 1 > MAXC) ? MAXC : m_time + 1;
          if (m_time == MAXC) begin m_state = 2; m_go = 0; end
        end
      end else begin
        if (FSE && press) begin m_state = 4; m_time = MAXC; end
        else if (t) m_cnt++;
      end
      2: if (press) m_state = 0;
      3: if (press && !s) m_state = 0;
      4: if (press) m_state = 0;
      default: m_state = 0;
    endcase
  endtask

  task automatic mdl_check();
    bit fresh = 0;
    if (m_state == 1 && !m_go) begin
      if (Go) begin
        chk("rnd_go_window", 32'(m_cnt >= MIN && m_cnt <= MIN + SPAN), 1);
        m_go = 1; fresh = 1;
      end else if (m_cnt > MIN + SPAN) begin
        chk("rnd_go_late", 32'(Go), 1);
        m_go = 1; fresh = 1;
      end
    end
    chk("rnd_state", 32'(State), m_state);
    chk("rnd_time", 32'(Time_ms), (m_state == 3) ? m_best : m_time);
    chk("rnd_best", 32'(Best_ms), m_best);
    chk("rnd_newbest", 32'(New_best), int'(m_nb));
    if (!fresh) chk("rnd_go", 32'(Go), int'(m_go));
  endtask

  task automatic step(input bit r, input bit k, input bit s, input bit t);
    Reset = r; Key = k; SW = s; Tick = t;
    @(posedge Clock);
    mdl_edge(r, k, s, t);
    #1;
    if (mdl_on) mdl_check();
  endtask

  task automatic wait_go(input int n0, output int n);
    n = n0;
    while (!Go && n < MIN + SPAN + 10) begin
      step(0, 0, 0, 1);
      n++;
    end
    chk("go_rise", 32'(Go), 1);
    chk("go_window", 32'(n >= MIN && n <= MIN + SPAN), 1);
    chk("go_time0", 32'(Time_ms), 0);
  endtask

  typedef struct {
    bit r, k, s, t;
    int st, go, tm, best, nb;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(bit r, bit k, bit s, bit t,
                              int st, int go, int tm, int best, int nb);
    vec_t v;
    v.r = r; v.k = k; v.s = s; v.t = t;
    v.st = st; v.go = go; v.tm = tm; v.best = best; v.nb = nb;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int trans;
    logic [2:0] prev;
    bit k;

    vecs[0]  = mk(1, 1, 0, 1, 0, 0, 0, MAXC, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, MAXC, 0);
    vecs[2]  = mk(0, 1, 1, 0, 3, 0, MAXC, MAXC, 0);
    vecs[3]  = mk(0, 1, 0, 0, 3, 0, MAXC, MAXC, 0);
    vecs[4]  = mk(0, 0, 0, 1, 3, 0, MAXC, MAXC, 0);
    vecs[5]  = mk(0, 1, 1, 0, 3, 0, MAXC, MAXC, 0);
    vecs[6]  = mk(0, 0, 0, 0, 3, 0, MAXC, MAXC, 0);
    vecs[7]  = mk(0, 1, 0, 0, 0, 0, 0, MAXC, 0);
    vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, MAXC, 0);
    vecs[9]  = mk(0, 1, 0, 1, 1, 0, 0, MAXC, 0);
    vecs[10] = mk(0, 0, 0, 1, 1, 0, 0, MAXC, 0);
    vecs[11] = FSE ? mk(0, 1, 0, 1, 4, 0, MAXC, MAXC, 0)
                   : mk(0, 1, 0, 1, 1, 0, 0, MAXC, 0);
    vecs[12] = FSE ? mk(0, 0, 0, 0, 4, 0, MAXC, MAXC, 0)
                   : mk(0, 0, 0, 0, 1, 0, 0, MAXC, 0);
    vecs[13] = FSE ? mk(0, 1, 0, 0, 0, 0, MAXC, MAXC, 0)
                   : mk(0, 1, 0, 0, 1, 0, 0, MAXC, 0);
    vecs[14] = mk(1, 0, 0, 0, 0, 0, 0, MAXC, 0);

    #1;
    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].k, vecs[i].s, vecs[i].t);
      chk($sformatf("vec%0d_state", i), 32'(State), vecs[i].st);
      chk($sformatf("vec%0d_go", i), 32'(Go), vecs[i].go);
      chk($sformatf("vec%0d_time", i), 32'(Time_ms), vecs[i].tm);
      chk($sformatf("vec%0d_best", i), 32'(Best_ms), vecs[i].best);
      chk($sformatf("vec%0d_nb", i), 32'(New_best), vecs[i].nb);
    end

    // First attempt: 237 ticks after go.
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("a1_start", 32'(State), 1);
    step(0, 0, 0, 0);
    wait_go(0, n);
    repeat (237) step(0, 0, 0, 1);
    chk("a1_run_time", 32'(Time_ms), 237);
    step(0, 1, 0, 0);
    chk("a1_state", 32'(State), 2);
    chk("a1_time", 32'(Time_ms), 237);
    chk("a1_best", 32'(Best_ms), 237);
    chk("a1_nb", 32'(New_best), 1);
    chk("a1_go", 32'(Go), 0);
    step(0, 0, 0, 1);
    chk("a1_nb_pulse", 32'(New_best), 0);
    chk("a1_frozen", 32'(Time_ms), 237);

    // Second attempt: slower, press coincides with a tick.
    step(0, 1, 0, 0);
    chk("a2_idle", 32'(State), 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("a2_start", 32'(State), 1);
    chk("a2_clear", 32'(Time_ms), 0);
    step(0, 0, 0, 0);
    wait_go(0, n);
    repeat (300) step(0, 0, 0, 1);
    step(0, 1, 0, 1);
    chk("a2_state", 32'(State), 2);
    chk("a2_time", 32'(Time_ms), 300);
    chk("a2_best", 32'(Best_ms), 237);
    chk("a2_nb", 32'(New_best), 0);
    step(0, 0, 0, 0);
    chk("a2_nb_after", 32'(New_best), 0);
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    step(0, 1, 1, 0);
    chk("score_state", 32'(State), 3);
    chk("score_time", 32'(Time_ms), 237);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("score_exit", 32'(State), 0);
    step(0, 0, 0, 0);

    // Timeout: go light left unanswered.
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    wait_go(0, n);
    repeat (MAXC - 1) step(0, 0, 0, 1);
    chk("to_pre_state", 32'(State), 1);
    chk("to_pre_time", 32'(Time_ms), MAXC - 1);
    step(0, 0, 0, 1);
    chk("to_state", 32'(State), 2);
    chk("to_time", 32'(Time_ms), MAXC);
    chk("to_go", 32'(Go), 0);
    chk("to_best", 32'(Best_ms), 237);
    chk("to_nb", 32'(New_best), 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);

    // Early press during the countdown.
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    repeat (10) step(0, 0, 0, 1);
    step(0, 1, 0, 1);
    if (FSE) begin
      chk("fs_state", 32'(State), 4);
      chk("fs_time", 32'(Time_ms), MAXC);
      chk("fs_best", 32'(Best_ms), 237);
      step(0, 0, 0, 0);
      step(0, 1, 0, 0);
      chk("fs_exit", 32'(State), 0);
    end else begin
      chk("fs_state", 32'(State), 1);
      chk("fs_go", 32'(Go), 0);
      step(0, 0, 0, 0);
      wait_go(11, n);
      step(0, 1, 0, 0);
      step(0, 0, 0, 0);
      step(0, 1, 0, 0);
      chk("fs_exit", 32'(State), 0);
    end
    step(0, 0, 0, 0);

    // Held key gives one press; reset wins over press and tick.
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    trans = 0;
    prev = State;
    repeat (50) begin
      step(0, 1, 0, 0);
      if (State != prev) trans++;
      prev = State;
    end
    chk("hold_trans", 32'(trans), 1);
    chk("hold_state", 32'(State), 1);
    step(0, 0, 0, 0);
    wait_go(0, n);
    step(1, 1, 0, 1);
    chk("rst_state", 32'(State), 0);
    chk("rst_go", 32'(Go), 0);
    chk("rst_best", 32'(Best_ms), MAXC);
    chk("rst_time", 32'(Time_ms), 0);
    chk("rst_nb", 32'(New_best), 0);

    // Random play against the reference model.
    step(1, 0, 0, 0);
    mdl_on = 1'b1;
    k = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      if ($urandom_range(0, 5) == 0) k = ~k;
      step($urandom_range(0, 4999) == 0, k,
           $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
    end
    mdl_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reaction_sequencer.md
REACTION_SEQUENCER -- requirements
Module: reaction_sequencer

Interface
REQ-001 SHALL have parameter MIN_DELAY, default 500, meaning minimum countdown in ms before the go light.
REQ-002 SHALL have parameter MAX_COUNT, default 9999, meaning the saturation value of the reaction and best-time registers.
REQ-003 SHALL have port Clock  input  1  system clock; all state updates on the rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port Key  input  1  player button, synchronous to Clock, active high while held.
REQ-006 SHALL have port SW  input  1  high-score view select.
REQ-007 SHALL have port Tick  input  1  one-cycle 1 kHz enable pulse (1 ms timebase).
REQ-008 SHALL have port State  output  3  current state encoding (IDLE=0, START=1, FINISH=2, SCORE=3, FOUL=4).
REQ-009 SHALL have port Go  output  1  go light; high only in START after the countdown expires.
REQ-010 SHALL have port Time_ms  output  14  reaction time of the current or last attempt.
REQ-011 SHALL have port Best_ms  output  14  lowest completed reaction time since reset.
REQ-012 SHALL have port New_best  output  1  one-cycle pulse when Best_ms is updated.

Function
REQ-013 SHALL detect a press as Key=1 in the current cycle and Key=0 in the previous cycle (registered); holding Key SHALL produce exactly one press.
REQ-014 SHALL run a 16-bit maximal-length LFSR (x^16+x^14+x^13+x^11+1), advanced every cycle, never all-zero.
REQ-015 In IDLE: press with SW=0 -> START; press with SW=1 -> SCORE; no press -> remain IDLE.
REQ-016 On entry to START, the countdown SHALL load MIN_DELAY + LFSR[10:0] ms (range 500..2547 at default), and Time_ms SHALL clear to 0.
REQ-017 In START, the countdown SHALL decrement once per Tick; the cycle it reaches 0, Go SHALL rise (registered, next cycle).
REQ-018 While Go=1, Time_ms SHALL increment once per Tick and saturate at MAX_COUNT.
REQ-019 In START with Go=1: a press -> FINISH, Time_ms frozen at its value in that cycle; a press coinciding with Tick SHALL NOT count that Tick.
REQ-020 In START with Go=1: Time_ms reaching MAX_COUNT -> FINISH with Time_ms=MAX_COUNT (timeout), no Best update.
REQ-021 On the START->FINISH transition by press, if Time_ms < Best_ms, Best_ms SHALL load Time_ms and New_best SHALL pulse for one cycle; equal values SHALL NOT update.
REQ-022 In FINISH: press -> IDLE; Go=0.
REQ-023 In SCORE: Time_ms SHALL display Best_ms; press with SW=0 -> IDLE; SW=0 without press -> remain SCORE.
REQ-024 Go SHALL be 0 in every state except START-after-expiry.
REQ-025 Unused State encodings SHALL return to IDLE on the next cycle.

Reset
REQ-026 Reset=1 at a rising edge SHALL force State=IDLE, Go=0, Time_ms=0, Best_ms=MAX_COUNT, New_best=0, countdown=0, press-detect register=0, LFSR=16'hACE1, regardless of current state or Key.
REQ-027 Reset SHALL take priority over any simultaneous press or Tick.

Configuration
REQ-028 Macro REACTION_FALSE_START_EN SHALL select false-start detection.
REQ-029 With REACTION_FALSE_START_EN defined: a press in START while Go=0 -> FOUL, Time_ms=MAX_COUNT, no Best update; in FOUL a press -> IDLE.
REQ-030 Without REACTION_FALSE_START_EN: presses in START while Go=0 SHALL be ignored, and the FOUL state SHALL be unreachable.

Verification
REQ-031 Reset, SW=0, press, countdown expires, press 237 Ticks after Go -> State=FINISH, Time_ms=237, Best_ms=237, New_best one pulse.
REQ-032 Following REQ-031, second attempt with press after 300 Ticks -> Time_ms=300, Best_ms=237, New_best stays 0; SW=1 press from IDLE -> SCORE, Time_ms=237.
REQ-033 Go=1, no press for 9999 Ticks -> FINISH, Time_ms=9999, Best_ms unchanged.
REQ-034 Press during countdown: with REACTION_FALSE_START_EN -> State=4, Time_ms=9999; without -> remains START, Go later rises normally.
REQ-035 Key held high for 50 cycles in IDLE -> exactly one transition to START; Reset asserted mid-START with Go=1 -> next cycle IDLE, Go=0, Best_ms=9999.
